// File: rtl/rdmx_packetizer.sv
// -----------------------------------------------------------------------------
// rdmx_packetizer
//
// Builds RDMX write packets (Ethernet / IPv4 / UDP / RDMX) for the transmit
// path. Each command {beats, address} produces one 64-byte header beat, then
// the payload beats are passed through unchanged. The block computes the IPv4
// total length, UDP length and IPv4 header checksum, and stamps an IPv4 ID
// that increments once per emitted header.
//
// Ports
//   clk                      sole clock
//   reset                    synchronous, active-high
//   src_mac, dst_mac         Ethernet addresses (big-endian numeric)
//   src_ip, dst_ip           IPv4 addresses
//   src_port, dst_port       UDP ports
//   AXIS_CMD_*               command stream, TDATA = {beats[7:0], address[63:0]}
//   AXIS_IN_*                payload stream (TLAST only checked, never forwarded)
//   AXIS_RDMX_*              packet output stream, TKEEP always all-ones
//   len_err                  one-cycle pulse when payload TLAST disagrees with
//                            the beat count from the command
//
// Byte order: wire byte k sits in TDATA[8k+7:8k]; multi-byte fields are sent
// most-significant byte first.
// -----------------------------------------------------------------------------
module rdmx_packetizer #(
    parameter logic [7:0] TTL = 8'd64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [47:0]  src_mac,
    input  logic [47:0]  dst_mac,
    input  logic [31:0]  src_ip,
    input  logic [31:0]  dst_ip,
    input  logic [15:0]  src_port,
    input  logic [15:0]  dst_port,
    input  logic [71:0]  AXIS_CMD_TDATA,
    input  logic         AXIS_CMD_TVALID,
    output logic         AXIS_CMD_TREADY,
    input  logic [511:0] AXIS_IN_TDATA,
    input  logic         AXIS_IN_TLAST,
    input  logic         AXIS_IN_TVALID,
    output logic         AXIS_IN_TREADY,
    output logic [511:0] AXIS_RDMX_TDATA,
    output logic [63:0]  AXIS_RDMX_TKEEP,
    output logic         AXIS_RDMX_TLAST,
    output logic         AXIS_RDMX_TVALID,
    input  logic         AXIS_RDMX_TREADY,
    output logic         len_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CSUM    = 2'd1;
    localparam logic [1:0] ST_HDR     = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    // IPv4 header checksum over the ten header words; the checksum field
    // itself counts as zero. Two folds are always enough for a 20-bit sum.
    function automatic logic [15:0] ip_csum_f(
        input logic [15:0] ip_len,
        input logic [15:0] ip_id,
        input logic [31:0] sip,
        input logic [31:0] dip
    );
        logic [19:0] sum;
        logic [19:0] fold1;
        logic [19:0] fold2;
        sum = 20'h04500
            + {4'h0, ip_len}
            + {4'h0, ip_id}
            + 20'h04000
            + {4'h0, TTL, 8'h11}
            + 20'h00000
            + {4'h0, sip[31:16]}
            + {4'h0, sip[15:0]}
            + {4'h0, dip[31:16]}
            + {4'h0, dip[15:0]};
        fold1 = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        fold2 = {4'h0, fold1[15:0]} + {16'h0000, fold1[19:16]};
        return ~fold2[15:0];
    endfunction

    // Turns a vector with wire byte 0 in the top bits into TDATA byte order.
    function automatic logic [511:0] wire_order_f(input logic [511:0] be);
        logic [511:0] w;
        for (int k = 0; k < 64; k++) begin
            w[8*k +: 8] = be[511 - 8*k -: 8];
        end
        return w;
    endfunction

    logic [1:0]   state_r;
    logic [1:0]   next_state_s;
    logic         cmd_ready_r;

    logic [47:0]  src_mac_r;
    logic [47:0]  dst_mac_r;
    logic [31:0]  src_ip_r;
    logic [31:0]  dst_ip_r;
    logic [15:0]  src_port_r;
    logic [15:0]  dst_port_r;
    logic [63:0]  addr_r;
    logic [7:0]   beats_r;

    logic [15:0]  ip_id_r;
    logic [15:0]  ip_len_r;
    logic [15:0]  udp_len_r;
    logic [15:0]  ip_csum_r;
    logic [7:0]   beat_cnt_r;
    logic         len_err_r;

    logic         cmd_hs_s;
    logic         hdr_hs_s;
    logic         pay_hs_s;
    logic         last_beat_s;
    logic [15:0]  ip_len_s;
    logic [15:0]  udp_len_s;
    logic [511:0] hdr_be_s;
    logic [511:0] hdr_wire_s;

    assign cmd_hs_s    = AXIS_CMD_TVALID & cmd_ready_r;
    assign hdr_hs_s    = (state_r == ST_HDR) & AXIS_RDMX_TREADY;
    assign pay_hs_s    = (state_r == ST_PAYLOAD) & AXIS_IN_TVALID & AXIS_RDMX_TREADY;
    // beat_cnt_r holds the number of payload beats already accepted.
    assign last_beat_s = (({1'b0, beat_cnt_r} + 9'd1) == {1'b0, beats_r});

    assign ip_len_s  = 16'd50 + {2'b00, beats_r, 6'b000000};
    assign udp_len_s = 16'd30 + {2'b00, beats_r, 6'b000000};

    // Header image with wire byte 0 at the MSB end; all fields come from
    // registers so the beat is stable while back-pressured.
    assign hdr_be_s = {
        dst_mac_r,
        src_mac_r,
        16'h0800,
        16'h4500,
        ip_len_r,
        ip_id_r,
        16'h4000,
        TTL, 8'h11,
        ip_csum_r,
        src_ip_r,
        dst_ip_r,
        src_port_r,
        dst_port_r,
        udp_len_r,
        16'h0000,
        16'h0122,
        addr_r,
        96'h0
    };
    assign hdr_wire_s = wire_order_f(hdr_be_s);

    assign AXIS_RDMX_TKEEP = {64{1'b1}};
    assign AXIS_CMD_TREADY = cmd_ready_r;
    assign len_err         = len_err_r;

    // Next-state logic of the packet sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) begin
                    next_state_s = ST_CSUM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CSUM: begin
                next_state_s = ST_HDR;
            end
            ST_HDR: begin
                if (hdr_hs_s) begin
                    if (beats_r == 8'd0) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (pay_hs_s && last_beat_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PAYLOAD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output stream mux: registered header in HDR, combinational pass-through
    // of the payload stream in PAYLOAD, quiet otherwise.
    always_comb begin
        AXIS_RDMX_TDATA  = 512'h0;
        AXIS_RDMX_TVALID = 1'b0;
        AXIS_RDMX_TLAST  = 1'b0;
        AXIS_IN_TREADY   = 1'b0;
        case (state_r)
            ST_HDR: begin
                AXIS_RDMX_TDATA  = hdr_wire_s;
                AXIS_RDMX_TVALID = 1'b1;
                AXIS_RDMX_TLAST  = (beats_r == 8'd0);
            end
            ST_PAYLOAD: begin
                AXIS_RDMX_TDATA  = AXIS_IN_TDATA;
                AXIS_RDMX_TVALID = AXIS_IN_TVALID;
                AXIS_RDMX_TLAST  = last_beat_s;
                AXIS_IN_TREADY   = AXIS_RDMX_TREADY;
            end
            default: begin
                AXIS_RDMX_TDATA  = 512'h0;
                AXIS_RDMX_TVALID = 1'b0;
                AXIS_RDMX_TLAST  = 1'b0;
                AXIS_IN_TREADY   = 1'b0;
            end
        endcase
    end

    // Sequencer state, command ready, IPv4 ID, beat counter and length check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            ip_id_r     <= 16'h0000;
            beat_cnt_r  <= 8'd0;
            len_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            // Ready is registered so it is low throughout reset and high in
            // the first cycle back in IDLE.
            cmd_ready_r <= (next_state_s == ST_IDLE);
            if (hdr_hs_s) begin
                ip_id_r <= ip_id_r + 16'd1;
            end else begin
                ip_id_r <= ip_id_r;
            end
            if (cmd_hs_s) begin
                beat_cnt_r <= 8'd0;
            end else if (pay_hs_s) begin
                if (last_beat_s) begin
                    beat_cnt_r <= 8'd0;
                end else begin
                    beat_cnt_r <= beat_cnt_r + 8'd1;
                end
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            // The command count decides packet length; input TLAST is only
            // compared against it.
            len_err_r <= pay_hs_s & (AXIS_IN_TLAST != last_beat_s);
        end
    end

    // Per-packet fields: configuration and command latched at the command
    // handshake, derived lengths and checksum captured in CSUM.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_mac_r  <= 48'h0;
            dst_mac_r  <= 48'h0;
            src_ip_r   <= 32'h0;
            dst_ip_r   <= 32'h0;
            src_port_r <= 16'h0;
            dst_port_r <= 16'h0;
            addr_r     <= 64'h0;
            beats_r    <= 8'd0;
            ip_len_r   <= 16'h0;
            udp_len_r  <= 16'h0;
            ip_csum_r  <= 16'h0;
        end else begin
            if (cmd_hs_s) begin
                src_mac_r  <= src_mac;
                dst_mac_r  <= dst_mac;
                src_ip_r   <= src_ip;
                dst_ip_r   <= dst_ip;
                src_port_r <= src_port;
                dst_port_r <= dst_port;
                addr_r     <= AXIS_CMD_TDATA[63:0];
                beats_r    <= AXIS_CMD_TDATA[71:64];
            end else begin
                src_mac_r  <= src_mac_r;
                dst_mac_r  <= dst_mac_r;
                src_ip_r   <= src_ip_r;
                dst_ip_r   <= dst_ip_r;
                src_port_r <= src_port_r;
                dst_port_r <= dst_port_r;
                addr_r     <= addr_r;
                beats_r    <= beats_r;
            end
            if (state_r == ST_CSUM) begin
                ip_len_r  <= ip_len_s;
                udp_len_r <= udp_len_s;
                ip_csum_r <= ip_csum_f(ip_len_s, ip_id_r, src_ip_r, dst_ip_r);
            end else begin
                ip_len_r  <= ip_len_r;
                udp_len_r <= udp_len_r;
                ip_csum_r <= ip_csum_r;
            end
        end
    end

endmodule
